// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a-b LSB first, one bit per clock, through an IDLE/RUN/DONE FSM.
// Optional borrow-in port enabled by defining SERIAL_SUB_BIN_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BIN_EN
  input  logic             bin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borr
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] work;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             brw_load;

  logic             x;
  logic             y;
  logic             d;
  logic             bout;
  logic [WIDTH-1:0] work_next;

`ifdef SERIAL_SUB_BIN_EN
  assign brw_load = bin;
`else
  assign brw_load = 1'b0;
`endif

  always_comb begin
    x         = sa[0];
    y         = sb[0];
    d         = x ^ y ^ brw;
    bout      = (~x & y) | (~(x ^ y) & brw);
    work_next = {d, work[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      work  <= '0;
      cnt   <= '0;
      brw   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      borr  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            work  <= '0;
            cnt   <= '0;
            brw   <= brw_load;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          work <= work_next;
          brw  <= bout;
          cnt  <= cnt + CW'(1);
          // The last bit's d and bout are taken straight from the combinational stage.
          if (cnt == LAST) begin
            diff  <= work_next;
            borr  <= bout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed WIDTH=8 vectors plus an exhaustive WIDTH=4 sweep.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic       bin8, bin4;
  logic       busy8, done8, borr8;
  logic       busy4, done4, borr4;
  logic [7:0] diff8;
  logic [3:0] diff4;

  int checks = 0;
  int errors = 0;

  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic [7:0] last_diff;
  logic       last_borr;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
`ifdef SERIAL_SUB_BIN_EN
    .bin(bin8),
`endif
    .busy(busy8), .done(done8), .diff(diff8), .borr(borr8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
`ifdef SERIAL_SUB_BIN_EN
    .bin(bin4),
`endif
    .busy(busy4), .done(done4), .diff(diff4), .borr(borr4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop the expected result whenever a DUT signals done.
  always @(negedge clk) begin
    if (!rst) begin
      chk("excl8", {31'd0, busy8 & done8}, 32'd0);
      if (done8) begin
        if (q8.size() == 0) chk("unexpected_done8", 32'd1, 32'd0);
        else begin
          logic [8:0] e;
          e = q8.pop_front();
          chk("diff8", {24'd0, diff8}, {24'd0, e[8:1]});
          chk("borr8", {31'd0, borr8}, {31'd0, e[0]});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done4) begin
      if (q4.size() == 0) chk("unexpected_done4", 32'd1, 32'd0);
      else begin
        logic [4:0] e;
        e = q4.pop_front();
        chk("diff4", {28'd0, diff4}, {28'd0, e[4:1]});
        chk("borr4", {31'd0, borr4}, {31'd0, e[0]});
      end
    end
  end

  // One WIDTH=8 operation with exact latency checks and operand scrambling during RUN.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_b, input logic tbin,
                      input logic [7:0] ed, input logic eb);
    q8.push_back({ed, eb});
    @(negedge clk);
    start8 = 1'b1; a8 = ta; b8 = tb_b; bin8 = tbin;
    @(negedge clk);
    start8 = 1'b0; a8 = ~ta; b8 = ~tb_b; bin8 = ~tbin;
    for (int i = 0; i < 8; i++) begin
      chk("busy8_run", {31'd0, busy8}, 32'd1);
      chk("hold8", {23'd0, diff8, borr8}, {23'd0, last_diff, last_borr});
      if (i == 3) start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
    end
    chk("done8_latency", {31'd0, done8}, 32'd1);
    last_diff = ed; last_borr = eb;
    @(negedge clk);
    chk("idle8_busy", {31'd0, busy8}, 32'd0);
    chk("idle8_done", {31'd0, done8}, 32'd0);
  endtask

  task automatic run4(input logic [3:0] ta, input logic [3:0] tb_b);
    int n;
    logic [4:0] m;
    m = {5'(ta) - 5'(tb_b)};
    q4.push_back({m[3:0], (ta < tb_b)});
    @(negedge clk);
    start4 = 1'b1; a4 = ta; b4 = tb_b;
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (!done4) chk("timeout4", 32'd1, 32'd0);
  endtask

  typedef struct { logic [7:0] a; logic [7:0] b; logic bin; logic [7:0] d; logic br; } vec_t;
  vec_t vecs[$];

  initial begin
    rst = 1'b1; start8 = 0; start4 = 0; a8 = 0; b8 = 0; a4 = 0; b4 = 0; bin8 = 0; bin4 = 0;
    last_diff = 8'h00; last_borr = 1'b0;
    // Dirty the inputs while reset is held: reset must win over start.
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'h77; b8 = 8'h11;
    @(negedge clk);
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    chk("rst_done8", {31'd0, done8}, 32'd0);
    chk("rst_diff8", {24'd0, diff8}, 32'd0);
    chk("rst_borr8", {31'd0, borr8}, 32'd0);
    chk("rst_diff4", {28'd0, diff4, busy4, done4, borr4}, 32'd0);
    start8 = 1'b0;
    rst = 1'b0;

    vecs.push_back('{8'h35, 8'h12, 1'b0, 8'h23, 1'b0});
    vecs.push_back('{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1});
    vecs.push_back('{8'hAA, 8'hAA, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0});
    vecs.push_back('{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1});
    vecs.push_back('{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{8'h01, 8'hFF, 1'b0, 8'h02, 1'b1});
`ifdef SERIAL_SUB_BIN_EN
    vecs.push_back('{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1});
    vecs.push_back('{8'h35, 8'h12, 1'b1, 8'h22, 1'b0});
`endif
    foreach (vecs[i]) run8(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].br);

    // start held high: one result for 0x50-0x20, then an immediate new op on FF-FF.
    q8.push_back({8'h30, 1'b0});
    q8.push_back({8'h00, 1'b0});
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h50; b8 = 8'h20; bin8 = 1'b0;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      chk("hold_busy8", {31'd0, busy8}, 32'd1);
      @(negedge clk);
    end
    chk("hold_done8", {31'd0, done8}, 32'd1);
    last_diff = 8'h30; last_borr = 1'b0;
    @(negedge clk);
    chk("hold_idle8", {30'd0, busy8, done8}, 32'd0);
    @(negedge clk);
    chk("hold_restart8", {31'd0, busy8}, 32'd1);
    chk("hold_keep8", {23'd0, diff8, borr8}, {23'd0, 8'h30, 1'b0});
    start8 = 1'b0;
    begin
      int n = 0;
      while (!done8 && n < 12) begin
        @(negedge clk);
        n++;
      end
      if (!done8) chk("timeout8", 32'd1, 32'd0);
    end
    last_diff = 8'h00;
    @(negedge clk);

    // Abort by reset in the 4th RUN cycle; first load a nonzero result so the clear is visible.
    run8(8'h35, 8'h12, 1'b0, 8'h23, 1'b0);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h44; b8 = 8'h01;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy8", {31'd0, busy8}, 32'd0);
    chk("abort_done8", {31'd0, done8}, 32'd0);
    chk("abort_diff8", {24'd0, diff8}, 32'd0);
    chk("abort_borr8", {31'd0, borr8}, 32'd0);
    last_diff = 8'h00; last_borr = 1'b0;
    repeat (10) @(negedge clk);
    run8(8'h35, 8'h12, 1'b0, 8'h23, 1'b0);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run4(4'(i), 4'(j));

    repeat (3) @(negedge clk);
    chk("q8_drained", q8.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
